// File: rtl/tagged_minmax_queue_pkg.sv
// Shared types and helpers for tagged_minmax_queue: FSM state encoding,
// default slot index type and the all-ones tag constant builder.
package tagged_minmax_queue_pkg;

    localparam int unsigned TMQ_TAG_MAX_W     = 128;
    localparam int unsigned TMQ_DEFAULT_DEPTH = 8;

    typedef enum logic [0:0] {
        READY = 1'b0,
        SCAN  = 1'b1
    } tmq_state_e;

    typedef logic [$clog2(TMQ_DEFAULT_DEPTH)-1:0] slot_idx_t;

    // Builds a right-aligned all-ones pattern of the requested width (<= TMQ_TAG_MAX_W).
    function automatic logic [TMQ_TAG_MAX_W-1:0] TAG_ALL_ONES(input int unsigned width);
        logic [TMQ_TAG_MAX_W-1:0] ones;
        ones = {TMQ_TAG_MAX_W{1'b1}};
        return ones >> (TMQ_TAG_MAX_W - width);
    endfunction

endpackage

// File: rtl/tmq_free_slot_enc.sv
// Lowest-index free slot priority encoder over the slot valid vector.
module tmq_free_slot_enc #(
    parameter int unsigned DEPTH = 8
) (
    input  logic [DEPTH-1:0]         valid,
    output logic [$clog2(DEPTH)-1:0] index,
    output logic                     any_free
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Walk from the top down so the lowest free index is the last one taken.
    always_comb begin
        index = {IDX_W{1'b0}};
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            index = valid[i] ? index : IDX_W'(i);
        end
    end

    assign any_free = ~(&valid);

endmodule

// File: rtl/tagged_minmax_queue.sv
// Double-ended (tag, data) priority store with min/max kept by a one-slot-per-cycle scan.
// Optional keep-best replacement when full: define TAGGED_MINMAX_QUEUE_KEEP_BEST_EN.
module tagged_minmax_queue
    import tagged_minmax_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     enq_valid_in,
    output logic                     enq_ready_out,
    input  logic [DATA_WIDTH-1:0]    enq_data_in,
    input  logic [TAG_WIDTH-1:0]     enq_tag_in,
    input  logic                     deq_valid_in,
    input  logic                     deq_max_in,
    output logic                     deq_ready_out,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [TAG_WIDTH-1:0]     tag_out,
    output logic                     valid_out,
    output logic [$clog2(DEPTH):0]   size_out,
    output logic                     empty_out,
    output logic                     full_out,
    output logic [TAG_WIDTH-1:0]     min_tag_out,
    output logic [TAG_WIDTH-1:0]     max_tag_out,
    output logic                     stats_valid_out
`ifdef TAGGED_MINMAX_QUEUE_KEEP_BEST_EN
    ,
    output logic                     drop_out
`endif
);

    localparam int unsigned          IDX_W    = $clog2(DEPTH);
    localparam int unsigned          SIZE_W   = IDX_W + 1;
    localparam logic [TAG_WIDTH-1:0] TAG_ONES = TAG_WIDTH'(TAG_ALL_ONES(TAG_WIDTH));
    localparam logic [SIZE_W-1:0]    DEPTH_SZ = SIZE_W'(DEPTH);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DEPTH - 1);

    tmq_state_e            state_r, state_nxt_s;

    logic [DEPTH-1:0]      valid_r;
    logic [TAG_WIDTH-1:0]  tag_mem_r  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
    logic [SIZE_W-1:0]     size_r;

    logic [TAG_WIDTH-1:0]  min_tag_r, max_tag_r;
    logic [IDX_W-1:0]      min_ptr_r, max_ptr_r;

    logic [IDX_W-1:0]      scan_idx_r;
    logic [TAG_WIDTH-1:0]  run_min_r, run_max_r;
    logic [IDX_W-1:0]      run_min_ptr_r, run_max_ptr_r;
    logic                  run_min_found_r, run_max_found_r;

    logic [DATA_WIDTH-1:0] data_out_r;
    logic [TAG_WIDTH-1:0]  tag_out_r;
    logic                  valid_out_r;

    logic                  full_s, empty_s;
    logic                  enq_ready_s, deq_ready_s, stats_valid_s;
    logic                  enq_fire_s, deq_fire_s;
    logic [IDX_W-1:0]      deq_ptr_s, enq_ptr_s, free_idx_s;
    logic                  any_free_s, enq_write_s, grow_s, scan_start_s, scan_last_s;
    logic                  drop_s;

    logic [TAG_WIDTH-1:0]  cur_tag_s, nxt_min_s, nxt_max_s;
    logic [IDX_W-1:0]      nxt_min_ptr_s, nxt_max_ptr_s;
    logic                  take_min_s, take_max_s;

    tmq_free_slot_enc #(.DEPTH(DEPTH)) u_free_enc (
        .valid    (valid_r),
        .index    (free_idx_s),
        .any_free (any_free_s)
    );

    assign full_s       = (size_r == DEPTH_SZ);
    assign empty_s      = (size_r == {SIZE_W{1'b0}});
    assign enq_fire_s   = enq_valid_in & enq_ready_s;
    assign deq_fire_s   = deq_valid_in & deq_ready_s;
    assign deq_ptr_s    = deq_max_in ? max_ptr_r : min_ptr_r;
    assign grow_s       = enq_write_s & (~full_s | deq_fire_s);
    assign scan_start_s = enq_write_s | deq_fire_s;
    assign scan_last_s  = (scan_idx_r == LAST_IDX);

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= READY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: any accepted change triggers a full DEPTH-cycle rescan.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            READY:   state_nxt_s = scan_start_s ? SCAN : READY;
            SCAN:    state_nxt_s = scan_last_s ? READY : SCAN;
            default: state_nxt_s = READY;
        endcase
    end

    // Handshake and stats-valid decode; independent of the valid inputs.
    always_comb begin
        enq_ready_s   = 1'b0;
        deq_ready_s   = 1'b0;
        stats_valid_s = 1'b0;
        case (state_r)
            READY: begin
`ifdef TAGGED_MINMAX_QUEUE_KEEP_BEST_EN
                enq_ready_s   = 1'b1;
`else
                enq_ready_s   = ~full_s;
`endif
                deq_ready_s   = ~empty_s;
                stats_valid_s = 1'b1;
            end
            SCAN: begin
                enq_ready_s   = 1'b0;
                deq_ready_s   = 1'b0;
                stats_valid_s = 1'b0;
            end
            default: begin
                enq_ready_s   = 1'b0;
                deq_ready_s   = 1'b0;
                stats_valid_s = 1'b0;
            end
        endcase
    end

    // Enqueue target: freed slot when full with a dequeue, else lowest free, else replacement.
    always_comb begin
        enq_write_s = 1'b0;
        enq_ptr_s   = free_idx_s;
        drop_s      = 1'b0;
        if (enq_fire_s) begin
            if (deq_fire_s && full_s) begin
                enq_write_s = 1'b1;
                enq_ptr_s   = deq_ptr_s;
            end else if (any_free_s) begin
                enq_write_s = 1'b1;
                enq_ptr_s   = free_idx_s;
`ifdef TAGGED_MINMAX_QUEUE_KEEP_BEST_EN
            end else if (enq_tag_in < max_tag_r) begin
                enq_write_s = 1'b1;
                enq_ptr_s   = max_ptr_r;
            end else begin
                drop_s      = 1'b1;
            end
`else
            end else begin
                enq_write_s = 1'b0;
            end
`endif
        end else begin
            enq_write_s = 1'b0;
        end
    end

    // Slot storage: the dequeue frees its slot first so a same-slot enqueue wins.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_mem_r[i]  <= {TAG_WIDTH{1'b0}};
                data_mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (deq_fire_s) begin
                valid_r[deq_ptr_s] <= 1'b0;
            end
            if (enq_write_s) begin
                valid_r[enq_ptr_s]    <= 1'b1;
                tag_mem_r[enq_ptr_s]  <= enq_tag_in;
                data_mem_r[enq_ptr_s] <= enq_data_in;
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            size_r <= {SIZE_W{1'b0}};
        end else begin
            case ({grow_s, deq_fire_s})
                2'b10:   size_r <= size_r + SIZE_W'(1);
                2'b01:   size_r <= size_r - SIZE_W'(1);
                default: size_r <= size_r;
            endcase
        end
    end

    // Running compare for the slot under scan; found flags make all-ones/zero tags still claim a pointer.
    always_comb begin
        cur_tag_s     = tag_mem_r[scan_idx_r];
        take_min_s    = valid_r[scan_idx_r] & (~run_min_found_r | (cur_tag_s < run_min_r));
        take_max_s    = valid_r[scan_idx_r] & (~run_max_found_r | (cur_tag_s > run_max_r));
        nxt_min_s     = take_min_s ? cur_tag_s  : run_min_r;
        nxt_min_ptr_s = take_min_s ? scan_idx_r : run_min_ptr_r;
        nxt_max_s     = take_max_s ? cur_tag_s  : run_max_r;
        nxt_max_ptr_s = take_max_s ? scan_idx_r : run_max_ptr_r;
    end

    // Scan sequencer and running min/max accumulators.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            scan_idx_r      <= {IDX_W{1'b0}};
            run_min_r       <= TAG_ONES;
            run_max_r       <= {TAG_WIDTH{1'b0}};
            run_min_ptr_r   <= {IDX_W{1'b0}};
            run_max_ptr_r   <= {IDX_W{1'b0}};
            run_min_found_r <= 1'b0;
            run_max_found_r <= 1'b0;
        end else if (state_r == SCAN) begin
            scan_idx_r      <= scan_idx_r + IDX_W'(1);
            run_min_r       <= nxt_min_s;
            run_max_r       <= nxt_max_s;
            run_min_ptr_r   <= nxt_min_ptr_s;
            run_max_ptr_r   <= nxt_max_ptr_s;
            run_min_found_r <= run_min_found_r | take_min_s;
            run_max_found_r <= run_max_found_r | take_max_s;
        end else if (scan_start_s) begin
            scan_idx_r      <= {IDX_W{1'b0}};
            run_min_r       <= TAG_ONES;
            run_max_r       <= {TAG_WIDTH{1'b0}};
            run_min_found_r <= 1'b0;
            run_max_found_r <= 1'b0;
        end
    end

    // Published min/max and cached pointers, committed once the last slot is examined.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            min_tag_r <= TAG_ONES;
            max_tag_r <= {TAG_WIDTH{1'b0}};
            min_ptr_r <= {IDX_W{1'b0}};
            max_ptr_r <= {IDX_W{1'b0}};
        end else if ((state_r == SCAN) && scan_last_s) begin
            min_tag_r <= nxt_min_s;
            max_tag_r <= nxt_max_s;
            min_ptr_r <= nxt_min_ptr_s;
            max_ptr_r <= nxt_max_ptr_s;
        end
    end

    // Dequeue response: payload captured at the accept edge, valid pulses one cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_out_r  <= {DATA_WIDTH{1'b0}};
            tag_out_r   <= {TAG_WIDTH{1'b0}};
            valid_out_r <= 1'b0;
        end else begin
            valid_out_r <= deq_fire_s;
            if (deq_fire_s) begin
                data_out_r <= data_mem_r[deq_ptr_s];
                tag_out_r  <= tag_mem_r[deq_ptr_s];
            end
        end
    end

`ifdef TAGGED_MINMAX_QUEUE_KEEP_BEST_EN
    logic drop_r;

    // Discard indication for offers that do not beat the current max.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            drop_r <= 1'b0;
        end else begin
            drop_r <= drop_s;
        end
    end

    assign drop_out = drop_r;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_s;
`endif

    assign enq_ready_out   = enq_ready_s;
    assign deq_ready_out   = deq_ready_s;
    assign stats_valid_out = stats_valid_s;
    assign data_out        = data_out_r;
    assign tag_out         = tag_out_r;
    assign valid_out       = valid_out_r;
    assign size_out        = size_r;
    assign empty_out       = empty_s;
    assign full_out        = full_s;
    assign min_tag_out     = min_tag_r;
    assign max_tag_out     = max_tag_r;

endmodule

// File: tb/tb_tagged_minmax_queue.sv
// Directed self-checking bench for tagged_minmax_queue (DEPTH=8, 32-bit tag/data).
module tb_tagged_minmax_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_data = 32'h0;
    logic [31:0] enq_tag = 32'h0;
    logic        deq_valid = 1'b0;
    logic        deq_max = 1'b0;
    logic        deq_ready;
    logic [31:0] data;
    logic [31:0] tag;
    logic        vout;
    logic [3:0]  size;
    logic        empty, full;
    logic [31:0] min_tag, max_tag;
    logic        stats;
`ifdef TAGGED_MINMAX_QUEUE_KEEP_BEST_EN
    logic        drop;
`endif

    int vectors = 0;
    int errors  = 0;
    int cyc;

    localparam logic [137:0] RESET_EXP = {4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
                                          32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0};

    tagged_minmax_queue #(.DATA_WIDTH(32), .TAG_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .enq_valid_in    (enq_valid),
        .enq_ready_out   (enq_ready),
        .enq_data_in     (enq_data),
        .enq_tag_in      (enq_tag),
        .deq_valid_in    (deq_valid),
        .deq_max_in      (deq_max),
        .deq_ready_out   (deq_ready),
        .data_out        (data),
        .tag_out         (tag),
        .valid_out       (vout),
        .size_out        (size),
        .empty_out       (empty),
        .full_out        (full),
        .min_tag_out     (min_tag),
        .max_tag_out     (max_tag),
        .stats_valid_out (stats)
`ifdef TAGGED_MINMAX_QUEUE_KEEP_BEST_EN
        ,
        .drop_out        (drop)
`endif
    );

    always #5 clk = ~clk;

    task automatic wait_stats(output int cycles);
        cycles = 0;
        while (stats !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic do_enq(input logic [31:0] t, input logic [31:0] d);
        enq_valid = 1'b1;
        enq_tag   = t;
        enq_data  = d;
        @(negedge clk);
        enq_valid = 1'b0;
    endtask

    task automatic do_deq(input logic mx);
        deq_valid = 1'b1;
        deq_max   = mx;
        @(negedge clk);
        deq_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [137:0] got;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        got = {size, empty, full, vout, data, tag, min_tag, max_tag, stats, enq_ready, deq_ready};
        vectors++;
        if (got !== RESET_EXP) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, RESET_EXP);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_enqueue_minmax;
        wait_stats(cyc);
        do_enq(32'd5, 32'hA);
        wait_stats(cyc);
        do_enq(32'd2, 32'hB);
        wait_stats(cyc);
        do_enq(32'd9, 32'hC);
        vectors++;
        if ({size, stats, enq_ready, max_tag} !== {4'd3, 1'b0, 1'b0, 32'd5}) begin
            errors++;
            $display("FAIL enq_during_scan: got size=%0d stats=%b rdy=%b max=%0d expected 3 0 0 5",
                     size, stats, enq_ready, max_tag);
        end
        wait_stats(cyc);
        vectors++;
        if (cyc !== DEPTH) begin
            errors++;
            $display("FAIL scan_length: got %0d expected %0d", cyc, DEPTH);
        end
        vectors++;
        if ({min_tag, max_tag} !== {32'd2, 32'd9}) begin
            errors++;
            $display("FAIL enq_minmax: got min=%0d max=%0d expected 2 9", min_tag, max_tag);
        end
    endtask

    task automatic test_dequeue;
        do_deq(1'b0);
        vectors++;
        if ({vout, tag, data, size} !== {1'b1, 32'd2, 32'hB, 4'd2}) begin
            errors++;
            $display("FAIL deq_min: got v=%b tag=%0d data=%h size=%0d expected 1 2 b 2",
                     vout, tag, data, size);
        end
        @(negedge clk);
        vectors++;
        if (vout !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse: got %b expected 0", vout);
        end
        wait_stats(cyc);
        do_deq(1'b1);
        vectors++;
        if ({vout, tag, data} !== {1'b1, 32'd9, 32'hC}) begin
            errors++;
            $display("FAIL deq_max: got v=%b tag=%0d data=%h expected 1 9 c", vout, tag, data);
        end
        wait_stats(cyc);
        vectors++;
        if ({size, min_tag, max_tag} !== {4'd1, 32'd5, 32'd5}) begin
            errors++;
            $display("FAIL deq_after: got size=%0d min=%0d max=%0d expected 1 5 5",
                     size, min_tag, max_tag);
        end
    endtask

    task automatic test_ties;
        do_enq(32'd7, 32'h71);
        wait_stats(cyc);
        do_enq(32'd3, 32'h73);
        wait_stats(cyc);
        do_enq(32'd7, 32'h72);
        wait_stats(cyc);
        do_deq(1'b1);
        vectors++;
        if ({tag, data} !== {32'd7, 32'h71}) begin
            errors++;
            $display("FAIL tie_lowest_index: got tag=%0d data=%h expected 7 71", tag, data);
        end
        wait_stats(cyc);
        vectors++;
        if ({size, min_tag, max_tag} !== {4'd3, 32'd3, 32'd7}) begin
            errors++;
            $display("FAIL tie_remaining: got size=%0d min=%0d max=%0d expected 3 3 7",
                     size, min_tag, max_tag);
        end
    endtask

    task automatic test_fill;
        logic [31:0] fill_tags [5];
        fill_tags = '{32'd20, 32'd30, 32'd40, 32'd11, 32'd12};
        for (int k = 0; k < 5; k++) begin
            do_enq(fill_tags[k], fill_tags[k]);
            wait_stats(cyc);
        end
        vectors++;
        if ({size, full, empty, min_tag, max_tag} !== {4'd8, 1'b1, 1'b0, 32'd3, 32'd40}) begin
            errors++;
            $display("FAIL fill: got size=%0d full=%b empty=%b min=%0d max=%0d expected 8 1 0 3 40",
                     size, full, empty, min_tag, max_tag);
        end
    endtask

    task automatic test_simultaneous;
`ifndef TAGGED_MINMAX_QUEUE_KEEP_BEST_EN
        do_deq(1'b0);
        vectors++;
        if ({tag, data, size} !== {32'd3, 32'h73, 4'd7}) begin
            errors++;
            $display("FAIL deq_from_full: got tag=%0d data=%h size=%0d expected 3 73 7", tag, data, size);
        end
        wait_stats(cyc);
`endif
        enq_valid = 1'b1;
        enq_tag   = 32'd1;
        enq_data  = 32'hD1;
        deq_valid = 1'b1;
        deq_max   = 1'b0;
        @(negedge clk);
        enq_valid = 1'b0;
        deq_valid = 1'b0;
        vectors++;
`ifdef TAGGED_MINMAX_QUEUE_KEEP_BEST_EN
        if ({tag, data, size} !== {32'd3, 32'h73, 4'd8}) begin
            errors++;
            $display("FAIL simul_full: got tag=%0d data=%h size=%0d expected 3 73 8", tag, data, size);
        end
`else
        if ({tag, data, size} !== {32'd5, 32'hA, 4'd7}) begin
            errors++;
            $display("FAIL simul: got tag=%0d data=%h size=%0d expected 5 a 7", tag, data, size);
        end
`endif
        wait_stats(cyc);
        vectors++;
        if ({min_tag, max_tag} !== {32'd1, 32'd40}) begin
            errors++;
            $display("FAIL simul_minmax: got min=%0d max=%0d expected 1 40", min_tag, max_tag);
        end
    endtask

    task automatic test_keep_best;
`ifdef TAGGED_MINMAX_QUEUE_KEEP_BEST_EN
        vectors++;
        if ({full, enq_ready} !== 2'b11) begin
            errors++;
            $display("FAIL kb_ready_full: got full=%b rdy=%b expected 1 1", full, enq_ready);
        end
        do_enq(32'd10, 32'h10);
        vectors++;
        if ({size, stats, drop} !== {4'd8, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL kb_replace: got size=%0d stats=%b drop=%b expected 8 0 0", size, stats, drop);
        end
        wait_stats(cyc);
        vectors++;
        if ({min_tag, max_tag} !== {32'd1, 32'd30}) begin
            errors++;
            $display("FAIL kb_recompute: got min=%0d max=%0d expected 1 30", min_tag, max_tag);
        end
        do_enq(32'd50, 32'h50);
        vectors++;
        if ({drop, stats, size, max_tag} !== {1'b1, 1'b1, 4'd8, 32'd30}) begin
            errors++;
            $display("FAIL kb_drop: got drop=%b stats=%b size=%0d max=%0d expected 1 1 8 30",
                     drop, stats, size, max_tag);
        end
        @(negedge clk);
        vectors++;
        if (drop !== 1'b0) begin
            errors++;
            $display("FAIL kb_drop_pulse: got %b expected 0", drop);
        end
        do_deq(1'b1);
        vectors++;
        if ({tag, data} !== {32'd30, 32'd30}) begin
            errors++;
            $display("FAIL kb_deq_max: got tag=%0d data=%h expected 30 1e", tag, data);
        end
        wait_stats(cyc);
`else
        do_enq(32'd60, 32'h60);
        wait_stats(cyc);
        enq_valid = 1'b1;
        enq_tag   = 32'd2;
        enq_data  = 32'h22;
        repeat (4) @(negedge clk);
        vectors++;
        if ({enq_ready, size, stats, min_tag, max_tag} !== {1'b0, 4'd8, 1'b1, 32'd1, 32'd60}) begin
            errors++;
            $display("FAIL full_stall: got rdy=%b size=%0d stats=%b min=%0d max=%0d expected 0 8 1 1 60",
                     enq_ready, size, stats, min_tag, max_tag);
        end
        enq_valid = 1'b0;
        do_deq(1'b1);
        vectors++;
        if ({tag, data, size} !== {32'd60, 32'h60, 4'd7}) begin
            errors++;
            $display("FAIL full_deq_max: got tag=%0d data=%h size=%0d expected 60 60 7", tag, data, size);
        end
        wait_stats(cyc);
`endif
    endtask

    task automatic test_reset_mid_scan;
        logic [137:0] got;
        do_enq(32'd99, 32'h99);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        got = {size, empty, full, vout, data, tag, min_tag, max_tag, stats, enq_ready, deq_ready};
        vectors++;
        if (got !== RESET_EXP) begin
            errors++;
            $display("FAIL reset_mid_scan: got %h expected %h", got, RESET_EXP);
        end
`ifdef TAGGED_MINMAX_QUEUE_KEEP_BEST_EN
        vectors++;
        if (drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: got %b expected 0", drop);
        end
`endif
        @(negedge clk);
        rst       = 1'b0;
        enq_valid = 1'b1;
        enq_tag   = 32'd4;
        enq_data  = 32'h44;
        #1;
        vectors++;
        if (enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", enq_ready);
        end
        @(negedge clk);
        enq_valid = 1'b0;
        vectors++;
        if ({size, stats} !== {4'd1, 1'b0}) begin
            errors++;
            $display("FAIL enq_after_reset: got size=%0d stats=%b expected 1 0", size, stats);
        end
        wait_stats(cyc);
        vectors++;
        if ({cyc, min_tag, max_tag} !== {DEPTH, 32'd4, 32'd4}) begin
            errors++;
            $display("FAIL post_reset_scan: got cyc=%0d min=%0d max=%0d expected %0d 4 4",
                     cyc, min_tag, max_tag, DEPTH);
        end
    endtask

    initial begin
        test_reset;
        test_enqueue_minmax;
        test_dequeue;
        test_ties;
        test_fill;
        test_simultaneous;
        test_keep_best;
        test_reset_mid_scan;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tagged_minmax_queue.md
Name: tagged_minmax_queue

Overview:
- Parametrised double-ended priority store of (tag, data) pairs, e.g. distance and point for k-nearest search.
- Dequeue returns either the smallest-tag or the largest-tag entry.
- Live min/max tags are kept by a sequential one-slot-per-cycle scan.
- Valid/ready handshakes throughout; optional keep-best replacement mode. Sits between candidate generators and the result collector.

Parameters:
DATA_WIDTH, 32, payload width
TAG_WIDTH, 32, tag (priority) width, unsigned compare
DEPTH, 8, slot count; power of two, >=2

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-high
enq_valid_in  in  1  enqueue request
enq_ready_out  out  1  enqueue accepted when high together with enq_valid_in
enq_data_in  in  DATA_WIDTH  payload to store
enq_tag_in  in  TAG_WIDTH  tag to store
deq_valid_in  in  1  dequeue request
deq_max_in  in  1  selects the entry to remove: 0 = smallest tag, 1 = largest tag
deq_ready_out  out  1  dequeue accepted when high together with deq_valid_in
data_out  out  DATA_WIDTH  dequeued payload
tag_out  out  TAG_WIDTH  dequeued tag
valid_out  out  1  one-cycle pulse qualifying data_out/tag_out
size_out  out  $clog2(DEPTH)+1  occupied slot count
empty_out  out  1  size_out==0
full_out  out  1  size_out==DEPTH
min_tag_out  out  TAG_WIDTH  smallest stored tag; all ones when empty
max_tag_out  out  TAG_WIDTH  largest stored tag; 0 when empty
stats_valid_out  out  1  min/max outputs and cached pointers are current (state READY)
drop_out  out  1  KEEP_BEST_EN only: one-cycle pulse when an offered entry is discarded

Behaviour:
- States: READY and SCAN. Reset enters READY.
- Reset values: all slot valid bits 0; size_out 0; empty_out 1; full_out 0; valid_out 0; data_out 0; tag_out 0; min_tag_out all ones; max_tag_out 0; drop_out 0; stats_valid_out 1.
- Reset is asynchronous. Asserting it mid-SCAN or mid-response aborts immediately to the reset values.
- Handshake rules:
  - enq_ready_out = READY && !full_out. Under KEEP_BEST_EN it is READY only.
  - deq_ready_out = READY && !empty_out.
  - Ports are combinational from state and size; they do not depend on the valid inputs.
- Dequeue accept at edge E:
  - The cached min or max slot, per deq_max_in, is invalidated and size decrements.
  - data_out/tag_out are registered at E; valid_out is high for exactly the cycle after E.
- Enqueue accept at edge E:
  - Writes the lowest-index free slot; size increments.
- Simultaneous enqueue and dequeue accept at the same edge:
  - Both take effect; size is unchanged.
  - If the queue was full, the enqueue writes the slot freed by the dequeue.
- Scan sequence:
  - Any accept moves the block to SCAN with i=0 and latches running min = all ones, max = 0.
  - Each SCAN cycle examines slot i against the post-update contents.
  - Min updates on strict <, max updates on strict >. Ties therefore resolve to the lowest index.
  - After slot DEPTH-1 is examined, the min/max outputs and pointers are updated and the block returns to READY.
- Throughput and timing:
  - SCAN lasts exactly DEPTH cycles, so the accept-to-next-accept minimum is DEPTH+1 cycles.
  - stats_valid_out is 0 throughout SCAN; min/max outputs hold their previous values during SCAN.
  - size_out, empty_out and full_out update at the accept edge.
- Empty queue: a dequeue cannot be accepted. Full queue without the optional feature: an enqueue cannot be accepted.

Optional Feature:
- Macro: TAGGED_MINMAX_QUEUE_KEEP_BEST_EN.
- Defined:
  - A full queue still accepts enqueues in READY.
  - If enq_tag_in < max_tag_out, the cached max slot is overwritten in place; size is unchanged and the block enters SCAN.
  - Otherwise the entry is discarded, drop_out pulses for one cycle, and no SCAN occurs.
  - With a simultaneous dequeue, replacement is not applied; the normal simultaneous rule governs.
- Undefined: drop_out is absent and full-queue enqueues stall.

Decomposition:
- Package tagged_minmax_queue_pkg holds:
  - state enum {READY, SCAN};
  - slot index typedef sized $clog2(DEPTH);
  - TAG_ALL_ONES constant function.
- Sub-module tmq_free_slot_enc: combinational lowest-free-index priority encoder over the valid vector. It outputs index and any_free.

Test Plan:
- Reset, then enqueue tags 5,2,9 with data A,B,C (DEPTH=8), each after stats_valid_out -> size 3; min 2, max 9 within DEPTH cycles of the last accept.
- Dequeue deq_max_in=0, then deq_max_in=1 -> tag_out 2/data B, then 9/data C; size 1; min=max=5.
- Enqueue tags 7,3,7 -> dequeue max returns the first-stored 7 (lowest index); min stays 3; the remaining 7 is still present.
- Fill to 8, then enqueue and dequeue-min in the same cycle with tag 1 -> size stays 8; the freed slot holds tag 1; the new min is 1 after the scan.
- KEEP_BEST_EN, full with max 40: offer tag 10 -> max slot replaced and max recomputed. Offer tag 50 -> drop_out pulse and contents unchanged. Without the macro, enq_ready_out stays 0.
- Assert rst_in mid-SCAN (i=3) -> all outputs take their reset values immediately; the next enqueue is accepted in the first cycle after rst_in deasserts.
